// File: rtl/shared_mem_ctrl.sv
// Shared word-array controller for two requesters: instruction fetch and
// data load (base + offset). One read in flight at a time, fixed read
// latency, ldr-first arbitration with a starvation guard for fetch, an
// always-available write port, and an error flag for out-of-range reads.
//
// state | meaning
// IDLE  | no read in flight; a pending request is granted at the next edge
// READ  | word captured at grant; counting down to the valid pulse
module shared_mem_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [ADDR_W-1:0] ldr_offset,
  output logic [DATA_W-1:0] ldr_data,
  output logic              ldr_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 3;
  localparam int SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [SW-1:0]    STARVE_L = SW'(STARVE_MAX);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [CNT_W-1:0]    lat_cnt;
  logic [SW-1:0]       starve_cnt;
  logic                owner_ldr;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_oor;

  logic                grant_f;
  logic                grant_l;
  logic                done;
  logic [ADDR_W-1:0]   ldr_eff;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                gnt_in_range;
  logic                wr_in_range;

  // Carry out of the base + offset sum is dropped on purpose (wraps).
  assign ldr_eff      = ldr_addr + ldr_offset;
  assign gnt_addr     = grant_f ? fetch_addr : ldr_eff;
  assign gnt_in_range = {1'b0, gnt_addr} < DEPTH_L;
  assign wr_in_range  = {1'b0, wr_addr} < DEPTH_L;
  assign busy         = (state == READ);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and arbitration: ldr wins ties unless fetch has lost STARVE_MAX in a row.
  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_l   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req && (!ldr_req || starve_cnt == STARVE_L)) begin
          grant_f   = 1'b1;
          state_nxt = READ;
        end else if (ldr_req) begin
          grant_l   = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (lat_cnt == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Word array; not cleared by reset, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  // Read datapath: capture at grant (old data on a same-edge write), deliver after the countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_data  <= '0;
      ldr_data    <= '0;
      fetch_valid <= 1'b0;
      ldr_valid   <= 1'b0;
      err         <= 1'b0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_ldr   <= 1'b0;
      rd_word     <= '0;
      rd_oor      <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      ldr_valid   <= 1'b0;
      err         <= 1'b0;
      if (grant_f || grant_l) begin
        owner_ldr <= grant_l;
        rd_word   <= gnt_in_range ? mem[gnt_addr[IDX_W-1:0]] : '0;
        rd_oor    <= !gnt_in_range;
        lat_cnt   <= LAT_INIT;
        // Fetch can only lose while below STARVE_MAX, so no saturation needed.
        if (grant_f)        starve_cnt <= '0;
        else if (fetch_req) starve_cnt <= starve_cnt + 1'b1;
      end else if (state == READ) begin
        if (done) begin
          err <= rd_oor;
          if (owner_ldr) begin
            ldr_data  <= rd_word;
            ldr_valid <= 1'b1;
          end else begin
            fetch_data  <= rd_word;
            fetch_valid <= 1'b1;
          end
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed bench for shared_mem_ctrl: a RD_LAT=1 / DEPTH=200 instance driven
// from a vector table plus arbitration and collision sequences, and a pair of
// RD_LAT=3 / RD_LAT=4 instances sharing stimulus for wrap, late-write and
// mid-read reset sequences.
module tb_shared_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A signals (RD_LAT=1, DEPTH=200)
  logic        a_rst;
  logic        a_freq, a_fvalid, a_lreq, a_lvalid, a_wen, a_busy, a_err;
  logic [15:0] a_faddr, a_fdata, a_laddr, a_loff, a_ldata, a_waddr, a_wdata;

  // Shared stimulus for instances B (RD_LAT=3) and C (RD_LAT=4)
  logic        s_rst;
  logic        s_freq, s_lreq, s_wen;
  logic [15:0] s_faddr, s_laddr, s_loff, s_waddr, s_wdata;
  logic        b_fvalid, b_lvalid, b_busy, b_err;
  logic [15:0] b_fdata, b_ldata;
  logic        c_fvalid, c_lvalid, c_busy, c_err;
  logic [15:0] c_fdata, c_ldata;

  shared_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(200), .RD_LAT(1), .STARVE_MAX(2)) dut_a (
    .clk(clk), .rst(a_rst),
    .fetch_req(a_freq), .fetch_addr(a_faddr), .fetch_data(a_fdata), .fetch_valid(a_fvalid),
    .ldr_req(a_lreq), .ldr_addr(a_laddr), .ldr_offset(a_loff), .ldr_data(a_ldata), .ldr_valid(a_lvalid),
    .wr_en(a_wen), .wr_addr(a_waddr), .wr_data(a_wdata), .busy(a_busy), .err(a_err)
  );

  shared_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(3), .STARVE_MAX(2)) dut_b (
    .clk(clk), .rst(s_rst),
    .fetch_req(s_freq), .fetch_addr(s_faddr), .fetch_data(b_fdata), .fetch_valid(b_fvalid),
    .ldr_req(s_lreq), .ldr_addr(s_laddr), .ldr_offset(s_loff), .ldr_data(b_ldata), .ldr_valid(b_lvalid),
    .wr_en(s_wen), .wr_addr(s_waddr), .wr_data(s_wdata), .busy(b_busy), .err(b_err)
  );

  shared_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(4), .STARVE_MAX(2)) dut_c (
    .clk(clk), .rst(s_rst),
    .fetch_req(s_freq), .fetch_addr(s_faddr), .fetch_data(c_fdata), .fetch_valid(c_fvalid),
    .ldr_req(s_lreq), .ldr_addr(s_laddr), .ldr_offset(s_loff), .ldr_data(c_ldata), .ldr_valid(c_lvalid),
    .wr_en(s_wen), .wr_addr(s_waddr), .wr_data(s_wdata), .busy(c_busy), .err(c_err)
  );

  typedef struct {
    bit          ldr;
    logic [15:0] addr;
    logic [15:0] off;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [15:0] ad, input logic [15:0] d);
    a_wen = 1'b1; a_waddr = ad; a_wdata = d;
    tick();
    a_wen = 1'b0;
  endtask

  // Single read on instance A; lat counts edges from raising req to seeing valid.
  task automatic a_read(input bit ldr, input logic [15:0] ad, input logic [15:0] off,
                        output logic [15:0] data, output logic e, output int lat,
                        output int busy_cnt, output logic both);
    if (ldr) begin a_lreq = 1'b1; a_laddr = ad; a_loff = off; end
    else     begin a_freq = 1'b1; a_faddr = ad; end
    lat = 0; busy_cnt = 0; both = 1'b0; data = '0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (a_busy) busy_cnt++;
      if (a_fvalid && a_lvalid) both = 1'b1;
      if (ldr ? a_lvalid : a_fvalid) begin
        data = ldr ? a_ldata : a_fdata;
        e    = a_err;
        break;
      end
    end
    a_freq = 1'b0; a_lreq = 1'b0;
  endtask

  // Single read on B and C together; optional write to word 4 one edge into READ.
  task automatic bc_read(input bit ldr, input logic [15:0] ad, input logic [15:0] off, input bit do_wr,
                         output int lat_b, output logic [15:0] d_b,
                         output int lat_c, output logic [15:0] d_c);
    if (ldr) begin s_lreq = 1'b1; s_laddr = ad; s_loff = off; end
    else     begin s_freq = 1'b1; s_faddr = ad; end
    lat_b = 0; lat_c = 0; d_b = '0; d_c = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (do_wr && i == 1) begin s_wen = 1'b1; s_waddr = 16'd4; s_wdata = 16'h9999; end
      if (i == 2) s_wen = 1'b0;
      if (lat_b == 0 && (ldr ? b_lvalid : b_fvalid)) begin
        lat_b = i; d_b = ldr ? b_ldata : b_fdata;
        s_lreq = 1'b0; s_freq = 1'b0;
      end
      if (lat_c == 0 && (ldr ? c_lvalid : c_fvalid)) begin
        lat_c = i; d_c = ldr ? c_ldata : c_fdata;
      end
      if (lat_b != 0 && lat_c != 0) break;
    end
    s_lreq = 1'b0; s_freq = 1'b0; s_wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d, d2, last_f, last_l;
    logic        e, both, bothv, bad_data, gap_bad, flag;
    logic [5:0]  ord;
    int          lat, lat2, bcnt, nv, last_t;

    vecs[0] = '{1'b0, 16'd5,      16'd0,      16'hA5A5, 1'b0};
    vecs[1] = '{1'b1, 16'h0010,   16'hFFF4,   16'h1234, 1'b0};
    vecs[2] = '{1'b0, 16'd250,    16'd0,      16'h0000, 1'b1};
    vecs[3] = '{1'b1, 16'h0100,   16'h0000,   16'h0000, 1'b1};
    vecs[4] = '{1'b0, 16'd199,    16'd0,      16'h7777, 1'b0};
    vecs[5] = '{1'b0, 16'd200,    16'd0,      16'h0000, 1'b1};
    vecs[6] = '{1'b1, 16'hFFFF,   16'h0001,   16'hBEEF, 1'b0};
    vecs[7] = '{1'b1, 16'h0008,   16'h0008,   16'h5555, 1'b0};
    vecs[8] = '{1'b0, 16'd261,    16'd0,      16'h0000, 1'b1};

    a_rst = 1'b0; a_freq = 0; a_lreq = 0; a_wen = 0;
    a_faddr = 0; a_laddr = 0; a_loff = 0; a_waddr = 0; a_wdata = 0;
    s_rst = 1'b0; s_freq = 0; s_lreq = 0; s_wen = 0;
    s_faddr = 0; s_laddr = 0; s_loff = 0; s_waddr = 0; s_wdata = 0;

    // ---------------- Instance A ----------------
    tick(); tick();
    chk("a_reset_outputs", {16'(a_fdata | a_ldata), 12'd0, a_fvalid, a_lvalid, a_busy, a_err}, 32'd0);
    a_rst = 1'b1;
    tick();

    a_write(16'd5,   16'hA5A5);
    a_write(16'd4,   16'h1234);
    a_write(16'd7,   16'h0001);
    a_write(16'd0,   16'hBEEF);
    a_write(16'd199, 16'h7777);
    a_write(16'd16,  16'h5555);
    a_write(16'd250, 16'hDEAD);
    a_write(16'd261, 16'hDEAD);

    last_f = 16'h0000; last_l = 16'h0000;
    for (int v = 0; v < 9; v++) begin
      a_read(vecs[v].ldr, vecs[v].addr, vecs[v].off, d, e, lat, bcnt, both);
      chk($sformatf("vec%0d_data", v), 32'(d), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_busy_cycles", v), 32'(bcnt), 32'd1);
      chk($sformatf("vec%0d_single_valid", v), 32'(both), 32'd0);
      if (vecs[v].ldr) begin
        last_l = vecs[v].exp_data;
        chk($sformatf("vec%0d_fetch_hold", v), 32'(a_fdata), 32'(last_f));
      end else begin
        last_f = vecs[v].exp_data;
        chk($sformatf("vec%0d_ldr_hold", v), 32'(a_ldata), 32'(last_l));
      end
      tick();
      chk($sformatf("vec%0d_err_one_cycle", v), 32'(a_err), 32'd0);
    end

    // Arbitration with both requests held: expect L L F L L F, one read per 2 cycles.
    a_freq = 1'b1; a_faddr = 16'd5; a_lreq = 1'b1; a_laddr = 16'd4; a_loff = 16'd0;
    ord = '0; nv = 0; bothv = 0; bad_data = 0; gap_bad = 0; last_t = 0;
    for (int i = 0; i < 40; i++) begin
      if (nv == 6) break;
      tick();
      if (a_fvalid && a_lvalid) bothv = 1'b1;
      if (a_fvalid || a_lvalid) begin
        ord = {ord[4:0], a_lvalid};
        if (a_lvalid && a_ldata !== 16'h1234) bad_data = 1'b1;
        if (a_fvalid && a_fdata !== 16'hA5A5) bad_data = 1'b1;
        if (nv > 0 && (i - last_t) != 2) gap_bad = 1'b1;
        last_t = i;
        nv++;
        if (nv == 6) begin a_freq = 1'b0; a_lreq = 1'b0; end
      end
    end
    a_freq = 1'b0; a_lreq = 1'b0;
    chk("arb_valid_count", 32'(nv), 32'd6);
    chk("arb_order", 32'(ord), 32'b110110);
    chk("arb_no_dual_valid", 32'(bothv), 32'd0);
    chk("arb_data", 32'(bad_data), 32'd0);
    chk("arb_throughput", 32'(gap_bad), 32'd0);
    tick();

    // Write to word 7 on the same edge as the grant: old data returned.
    a_freq = 1'b1; a_faddr = 16'd7;
    a_wen = 1'b1; a_waddr = 16'd7; a_wdata = 16'h0002;
    tick();
    a_wen = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_fvalid) begin flag = 1'b1; break; end
    end
    a_freq = 1'b0;
    chk("collide_valid_seen", 32'(flag), 32'd1);
    chk("collide_old_data", 32'(a_fdata), 32'h0001);
    tick();
    a_read(1'b0, 16'd7, 16'd0, d, e, lat, bcnt, both);
    chk("collide_new_data", 32'(d), 32'h0002);

    // ---------------- Instances B (RD_LAT=3) and C (RD_LAT=4) ----------------
    tick(); tick();
    chk("bc_reset_outputs",
        {16'(b_fdata | b_ldata | c_fdata | c_ldata), 8'd0, b_fvalid, b_lvalid, b_busy, b_err,
         c_fvalid, c_lvalid, c_busy, c_err}, 32'd0);
    s_rst = 1'b1;
    tick();
    s_wen = 1'b1; s_waddr = 16'd4; s_wdata = 16'h1234;
    tick();
    s_wen = 1'b0;

    // Wrapped load address, with a write to the same word while in READ.
    bc_read(1'b1, 16'h0010, 16'hFFF4, 1'b1, lat, d, lat2, d2);
    chk("b_wrap_latency", 32'(lat), 32'd4);
    chk("b_wrap_data", 32'(d), 32'h1234);
    chk("c_wrap_latency", 32'(lat2), 32'd5);
    chk("c_wrap_data", 32'(d2), 32'h1234);
    for (int i = 0; i < 6; i++) tick();

    // Reset pulse one edge into READ.
    s_freq = 1'b1; s_faddr = 16'd4;
    tick();
    chk("bc_busy_after_grant", {30'd0, b_busy, c_busy}, 32'b11);
    tick();
    s_rst = 1'b0;
    s_freq = 1'b0;
    #1;
    chk("bc_reset_mid_read", {28'd0, b_busy, c_busy, b_fvalid | b_lvalid, c_fvalid | c_lvalid}, 32'd0);
    @(posedge clk);
    #1;
    s_rst = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b_fvalid || b_lvalid || c_fvalid || c_lvalid || b_busy || c_busy) flag = 1'b1;
    end
    chk("bc_no_valid_after_reset", 32'(flag), 32'd0);

    // Array contents survive reset; next request serviced normally.
    bc_read(1'b0, 16'd4, 16'd0, 1'b0, lat, d, lat2, d2);
    chk("b_post_reset_latency", 32'(lat), 32'd4);
    chk("b_post_reset_data", 32'(d), 32'h9999);
    chk("c_post_reset_latency", 32'(lat2), 32'd5);
    chk("c_post_reset_data", 32'(d2), 32'h9999);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
